// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter: shares one Avalon-MM master port between the
// instruction-fetch requester (I, read only) and the load/store requester (D).
// One transaction at a time; bus fields are held while waitrequest is high;
// the granted port gets a registered one-cycle ack with read data and err.
// Optional feature macro: ARB_TIMEOUT_EN (abort a stalled transfer after
// TIMEOUT_CYCLES consecutive waitrequest cycles).
module mips_avalon_arbiter #(
   parameter bit D_PRIORITY     = 1'b1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

   state_t      state;
   logic        gnt_d;      // 1 = current transaction belongs to D
   logic        we_r;       // latched direction of current transaction
   logic        pick_d;     // D wins arbitration this cycle
   logic [31:0] sel_addr;   // address of the arbitration winner
   logic        misaligned; // winner's address is not word aligned

   // A timeout of zero cycles would abort every transfer before it starts.
   generate
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] stall_cnt;
`endif

   // Fixed-priority arbitration and alignment check of the winner.
   always_comb begin
      if (d_req && i_req) begin
         pick_d = D_PRIORITY;
      end else begin
         pick_d = d_req;
      end
      if (pick_d) begin
         sel_addr = d_addr;
      end else begin
         sel_addr = i_addr;
      end
      misaligned = (sel_addr[1:0] != 2'b00);
   end

   // Transaction FSM with all bus and requester outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         gnt_d      <= 1'b0;
         we_r       <= 1'b0;
         read       <= 1'b0;
         write      <= 1'b0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         i_err      <= 1'b0;
         d_err      <= 1'b0;
         busy       <= 1'b0;
         address    <= 32'h0000_0000;
         writedata  <= 32'h0000_0000;
         byteenable <= 4'b0000;
         i_rdata    <= 32'h0000_0000;
         d_rdata    <= 32'h0000_0000;
`ifdef ARB_TIMEOUT_EN
         stall_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  gnt_d   <= pick_d;
                  address <= sel_addr;
                  busy    <= 1'b1;
                  if (pick_d) begin
                     we_r       <= d_we;
                     writedata  <= d_wdata;
                     byteenable <= d_be;
                  end else begin
                     we_r       <= 1'b0;
                     writedata  <= 32'h0000_0000;
                     byteenable <= 4'b1111;
                  end
                  if (misaligned) begin
                     // Rejected without touching the bus.
                     state <= DONE;
                     if (pick_d) begin
                        d_ack <= 1'b1;
                        d_err <= 1'b1;
                     end else begin
                        i_ack <= 1'b1;
                        i_err <= 1'b1;
                     end
                  end else begin
                     state <= BUS;
                     read  <= pick_d ? !d_we : 1'b1;
                     write <= pick_d & d_we;
`ifdef ARB_TIMEOUT_EN
                     stall_cnt <= '0;
`endif
                  end
               end else begin
                  state <= IDLE;
               end
            end
            BUS: begin
               if (!waitrequest) begin
                  read  <= 1'b0;
                  write <= 1'b0;
                  state <= DONE;
                  if (gnt_d) begin
                     d_ack <= 1'b1;
                     d_err <= 1'b0;
                     if (!we_r) begin
                        d_rdata <= readdata;
                     end else begin
                        d_rdata <= d_rdata;
                     end
                  end else begin
                     i_ack   <= 1'b1;
                     i_err   <= 1'b0;
                     i_rdata <= readdata;
                  end
`ifdef ARB_TIMEOUT_EN
               end else if (stall_cnt == CNT_LAST) begin
                  // Slave stalled too long: abort with err and zero data.
                  read  <= 1'b0;
                  write <= 1'b0;
                  state <= DONE;
                  if (gnt_d) begin
                     d_ack <= 1'b1;
                     d_err <= 1'b1;
                     if (!we_r) begin
                        d_rdata <= 32'h0000_0000;
                     end else begin
                        d_rdata <= d_rdata;
                     end
                  end else begin
                     i_ack   <= 1'b1;
                     i_err   <= 1'b1;
                     i_rdata <= 32'h0000_0000;
                  end
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
`else
               end else begin
                  state <= BUS;
`endif
               end
            end
            DONE: begin
               i_ack <= 1'b0;
               d_ack <= 1'b0;
               i_err <= 1'b0;
               d_err <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               read  <= 1'b0;
               write <= 1'b0;
               i_ack <= 1'b0;
               d_ack <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Self-checking bench for mips_avalon_arbiter. The bench plays both
// requesters and the Avalon slave; expectations come from transaction-level
// rules (winner choice, latency = 1 + stalls to strobe end, ack one cycle
// later, per-port read-data memory).
module tb_mips_avalon_arbiter;

   localparam bit DP = 1'b1;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, waitrequest;
   logic [31:0] i_addr, d_addr, d_wdata, readdata;
   logic [3:0]  d_be;
   logic        i_ack, i_err, d_ack, d_err, read, write, busy;
   logic [31:0] i_rdata, d_rdata, address, writedata;
   logic [3:0]  byteenable;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] i_rdata_m = 32'h0;
   logic [31:0] d_rdata_m = 32'h0;

   mips_avalon_arbiter #(.D_PRIORITY(DP), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .address(address), .read(read), .write(write), .waitrequest(waitrequest),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic post_i(input logic [31:0] a);
      i_req  = 1'b1;
      i_addr = a;
   endtask

   task automatic post_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      d_be    = be;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      return a;
   endfunction

   // Called in an IDLE cycle with the request(s) already driven.
   task automatic serve(input bit is_d, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int stalls, input logic [31:0] rdat, input bit keep);
      bit mis;
      mis = (a[1:0] != 2'b00);
      check("idle_busy", 32'(busy), 32'h0);
      tick();
      if (!mis) begin
         for (int k = 0; k <= stalls; k++) begin
            check("bus_read", 32'(read), 32'(!we));
            check("bus_write", 32'(write), 32'(we));
            check("bus_addr", address, a);
            check("bus_be", 32'(byteenable), 32'(be));
            check("bus_busy", 32'(busy), 32'h1);
            if (we) check("bus_wdata", writedata, wd);
            waitrequest = (k < stalls);
            readdata    = (k < stalls) ? $urandom : rdat;
            tick();
         end
         waitrequest = 1'b0;
      end
      // DONE cycle
      check("done_strobes", {30'h0, read, write}, 32'h0);
      check("done_busy", 32'(busy), 32'h1);
      if (is_d) begin
         if (!we && !mis) d_rdata_m = rdat;
         check("d_ack", 32'(d_ack), 32'h1);
         check("d_err", 32'(d_err), 32'(mis));
         check("i_ack_quiet", 32'(i_ack), 32'h0);
         check("d_rdata", d_rdata, d_rdata_m);
      end else begin
         if (!mis) i_rdata_m = rdat;
         check("i_ack", 32'(i_ack), 32'h1);
         check("i_err", 32'(i_err), 32'(mis));
         check("d_ack_quiet", 32'(d_ack), 32'h0);
         check("i_rdata", i_rdata, i_rdata_m);
      end
      tick();
      check("post_acks", {30'h0, i_ack, d_ack}, 32'h0);
      if (!keep) begin
         if (is_d) d_req = 1'b0;
         else i_req = 1'b0;
      end
   endtask

   // Random single-requester transaction, optionally followed back-to-back.
   task automatic rand_txn(input bit is_d, input bit keep);
      bit we;
      logic [31:0] a, wd;
      logic [3:0] be;
      we = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = rand_addr();
      wd = $urandom;
      be = is_d ? 4'($urandom_range(0, 15)) : 4'b1111;
      if (is_d) post_d(we, a, wd, be);
      else post_i(a);
      serve(is_d, we, a, wd, be, $urandom_range(0, 3), $urandom, keep);
   endtask

   initial begin
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; waitrequest = 1'b0;
      i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; readdata = 32'h0;
      tick(); tick();
      check("rst_strobes", {27'h0, read, write, i_ack, d_ack, busy}, 32'h0);
      check("rst_err", {30'h0, i_err, d_err}, 32'h0);
      check("rst_addr", address, 32'h0);
      check("rst_wdata", writedata, 32'h0);
      check("rst_be", 32'(byteenable), 32'h0);
      check("rst_rdata", i_rdata | d_rdata, 32'h0);
      reset = 1'b0;
      tick();

      // Single I read, no stall.
      post_i(32'hBFC0_0000);
      serve(1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 4'b1111, 0, 32'h3C02_0005, 1'b0);

      // D write with three stall cycles; d_rdata must stay put.
      post_d(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
      serve(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 3, 32'h1234_5678, 1'b0);

      // Simultaneous requests: winner first, loser in the following IDLE.
      post_i(32'h0040_0010);
      post_d(1'b0, 32'h0000_2004, 32'h0, 4'b1111);
      if (DP) begin
         serve(1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'b1111, 1, 32'hA5A5_0001, 1'b0);
         serve(1'b0, 1'b0, 32'h0040_0010, 32'h0, 4'b1111, 0, 32'h5A5A_0002, 1'b0);
      end else begin
         serve(1'b0, 1'b0, 32'h0040_0010, 32'h0, 4'b1111, 0, 32'h5A5A_0002, 1'b0);
         serve(1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'b1111, 1, 32'hA5A5_0001, 1'b0);
      end

      // Misaligned D read: error ack without bus activity.
      post_d(1'b0, 32'h0000_0002, 32'h0, 4'b1111);
      serve(1'b1, 1'b0, 32'h0000_0002, 32'h0, 4'b1111, 0, 32'h0, 1'b0);

      // Write with no byte enables still goes out on the bus.
      post_d(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'b0000);
      serve(1'b1, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 4'b0000, 0, 32'h0, 1'b0);

      // Reset while stalled in BUS.
      post_i(32'h0000_0100);
      tick();
      check("pre_rst_read", 32'(read), 32'h1);
      waitrequest = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_read", 32'(read), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_ack", 32'(i_ack), 32'h0);
      reset = 1'b0; i_req = 1'b0; waitrequest = 1'b0;
      i_rdata_m = 32'h0; d_rdata_m = 32'h0;
      tick();
      check("post_rst_ack", 32'(i_ack), 32'h0);
      post_i(32'h0000_0200);
      serve(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'b1111, 2, 32'h0BAD_F00D, 1'b0);

      // Randomized traffic.
      for (int it = 0; it < 250; it++) begin
         int kind;
         bit b2b;
         kind = $urandom_range(0, 2);
         b2b  = ($urandom_range(0, 3) == 0);
         if (kind == 2) begin
            logic [31:0] ia, da, dwd;
            logic [3:0] dbe;
            bit dwe;
            ia = rand_addr(); da = rand_addr(); dwd = $urandom;
            dbe = 4'($urandom_range(0, 15)); dwe = 1'($urandom_range(0, 1));
            post_i(ia);
            post_d(dwe, da, dwd, dbe);
            if (DP) begin
               serve(1'b1, dwe, da, dwd, dbe, $urandom_range(0, 3), $urandom, 1'b0);
               serve(1'b0, 1'b0, ia, 32'h0, 4'b1111, $urandom_range(0, 3), $urandom, 1'b0);
            end else begin
               serve(1'b0, 1'b0, ia, 32'h0, 4'b1111, $urandom_range(0, 3), $urandom, 1'b0);
               serve(1'b1, dwe, da, dwd, dbe, $urandom_range(0, 3), $urandom, 1'b0);
            end
         end else begin
            rand_txn(kind == 1, b2b);
            if (b2b) rand_txn(kind == 1, 1'b0);
         end
      end

`ifdef ARB_TIMEOUT_EN
      // Slave never releases: abort after four stalled cycles.
      post_i(32'h0000_0400);
      waitrequest = 1'b1;
      i_rdata_m = 32'h0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("to_read_held", 32'(read), 32'h1);
      end
      tick();
      check("to_read_drop", 32'(read), 32'h0);
      check("to_i_ack", 32'(i_ack), 32'h1);
      check("to_i_err", 32'(i_err), 32'h1);
      check("to_i_rdata", i_rdata, 32'h0);
      i_req = 1'b0; waitrequest = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
